// File: rtl/id_ibuf_stage.sv
// Decode-stage front end: DEPTH-entry instruction queue between fetch and decode, plus a
// shift-register scoreboard of in-flight long-latency writers that holds back dependent issue.
module id_ibuf_stage #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned HAZ_DEPTH = 1,
  parameter int unsigned INST_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       br_taken_i,
  input  logic                       fs_valid_i,
  output logic                       fs_ready_o,
  input  logic [INST_W-1:0]          fs_pc_i,
  input  logic [INST_W-1:0]          fs_inst_i,
  input  logic                       fs_excp_adef_i,
  output logic                       ds_valid_o,
  input  logic                       ds_ready_i,
  output logic [INST_W-1:0]          ds_pc_o,
  output logic [INST_W-1:0]          ds_inst_o,
  output logic                       ds_excp_adef_o,
  input  logic                       dec_src_reg_is_rd_i,
  input  logic                       dec_reg_we_i,
  input  logic                       dec_long_lat_i,
  input  logic [4:0]                 dec_dest_i,
  output logic                       stallreq_ds_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [INST_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [DEPTH-1:0]  adef_mem_q;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [HAZ_DEPTH-1:0]      sb_v_q, sb_v_d;
  logic [HAZ_DEPTH-1:0][4:0] sb_d_q, sb_d_d;

  logic              empty;
  logic              hazard;
  logic              push;
  logic              pop;
  logic [INST_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;
  logic              head_adef;
  logic [4:0]        rj;
  logic [4:0]        rkd;

  assign empty      = (count_q == '0);
  assign fs_ready_o = (count_q != DepthC);
  assign count_o    = count_q;

  assign head_pc   = pc_mem_q[rd_ptr_q];
  assign head_inst = inst_mem_q[rd_ptr_q];
  assign head_adef = adef_mem_q[rd_ptr_q];

  assign rj  = head_inst[9:5];
  assign rkd = dec_src_reg_is_rd_i ? head_inst[4:0] : head_inst[14:10];

  // r0 never carries a dependency; ADEF entries carry no real operands.
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < HAZ_DEPTH; s++) begin
      if (sb_v_q[s] && (((sb_d_q[s] == rj) && (rj != 5'd0)) ||
                        ((sb_d_q[s] == rkd) && (rkd != 5'd0)))) begin
        hazard = 1'b1;
      end
    end
    if (head_adef) begin
      hazard = 1'b0;
    end
  end

  assign ds_valid_o     = !empty && !hazard;
  assign stallreq_ds_o  = !empty && hazard;
  assign ds_pc_o        = ds_valid_o ? head_pc : '0;
  assign ds_inst_o      = ds_valid_o ? head_inst : '0;
  assign ds_excp_adef_o = ds_valid_o && head_adef;

  assign push = fs_valid_i && fs_ready_o && !flush_i && !br_taken_i;
  assign pop  = ds_valid_o && ds_ready_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (br_taken_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Slot 0 records the instruction leaving decode this cycle; older slots age toward MEM.
  always_comb begin
    sb_v_d = sb_v_q;
    sb_d_d = sb_d_q;
    if (ds_ready_i) begin
      sb_v_d[0] = pop && dec_long_lat_i && dec_reg_we_i && (dec_dest_i != 5'd0);
      sb_d_d[0] = dec_dest_i;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        sb_v_d[i] = sb_v_q[i-1];
        sb_d_d[i] = sb_d_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sb_v_q   <= '0;
      sb_d_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sb_v_q   <= sb_v_d;
      sb_d_q   <= sb_d_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fs_pc_i;
      inst_mem_q[wr_ptr_q] <= fs_inst_i;
      adef_mem_q[wr_ptr_q] <= fs_excp_adef_i;
    end
  end

endmodule

// File: tb/tb_id_ibuf_stage.sv
// Directed bench for id_ibuf_stage: a HAZ_DEPTH=1 and a HAZ_DEPTH=2 instance share stimulus;
// issued entries of the first are checked in order against a queue of expected entries.
module tb_id_ibuf_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        br_taken;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adef;
  logic        ds_ready;
  logic        dec_rd;
  logic        dec_we;
  logic        dec_ll;
  logic [4:0]  dec_dest;

  logic        fs_ready, ds_valid, ds_adef, stall;
  logic [31:0] ds_pc, ds_inst;
  logic [2:0]  count;
  logic        fs_ready2, ds_valid2, ds_adef2, stall2;
  logic [31:0] ds_pc2, ds_inst2;
  logic [2:0]  count2;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  logic [64:0] scb[$];

  id_ibuf_stage #(.DEPTH(4), .HAZ_DEPTH(1), .INST_W(32)) u_dut (
    .clk(clk), .reset(reset), .flush_i(flush), .br_taken_i(br_taken),
    .fs_valid_i(fs_valid), .fs_ready_o(fs_ready), .fs_pc_i(fs_pc), .fs_inst_i(fs_inst),
    .fs_excp_adef_i(fs_adef), .ds_valid_o(ds_valid), .ds_ready_i(ds_ready),
    .ds_pc_o(ds_pc), .ds_inst_o(ds_inst), .ds_excp_adef_o(ds_adef),
    .dec_src_reg_is_rd_i(dec_rd), .dec_reg_we_i(dec_we), .dec_long_lat_i(dec_ll),
    .dec_dest_i(dec_dest), .stallreq_ds_o(stall), .count_o(count)
  );

  id_ibuf_stage #(.DEPTH(4), .HAZ_DEPTH(2), .INST_W(32)) u_dut2 (
    .clk(clk), .reset(reset), .flush_i(flush), .br_taken_i(br_taken),
    .fs_valid_i(fs_valid), .fs_ready_o(fs_ready2), .fs_pc_i(fs_pc), .fs_inst_i(fs_inst),
    .fs_excp_adef_i(fs_adef), .ds_valid_o(ds_valid2), .ds_ready_i(ds_ready),
    .ds_pc_o(ds_pc2), .ds_inst_o(ds_inst2), .ds_excp_adef_o(ds_adef2),
    .dec_src_reg_is_rd_i(dec_rd), .dec_reg_we_i(dec_we), .dec_long_lat_i(dec_ll),
    .dec_dest_i(dec_dest), .stallreq_ds_o(stall2), .count_o(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rj,
                                       input logic [4:0] rk);
    return {17'h00020, rk, rj, rd};
  endfunction

  function automatic logic [31:0] mk_ld(input logic [4:0] rd, input logic [4:0] rj);
    return {10'h0A2, 12'h000, rj, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    fs_valid = 1'b0;
    fs_pc    = '0;
    fs_inst  = '0;
    fs_adef  = 1'b0;
    ds_ready = 1'b0;
    flush    = 1'b0;
    br_taken = 1'b0;
    dec_rd   = 1'b0;
    dec_we   = 1'b0;
    dec_ll   = 1'b0;
    dec_dest = '0;
  endtask

  task automatic drive_push(input logic [31:0] pc, input logic [31:0] inst, input logic adef);
    fs_valid = 1'b1;
    fs_pc    = pc;
    fs_inst  = inst;
    fs_adef  = adef;
  endtask

  task automatic exp_issue(input logic [31:0] pc, input logic [31:0] inst, input logic adef);
    scb.push_back({pc, inst, adef});
  endtask

  task automatic dec_load(input logic [4:0] dest);
    dec_we = 1'b1; dec_ll = 1'b1; dec_dest = dest;
  endtask

  task automatic dec_alu(input logic [4:0] dest);
    dec_we = 1'b1; dec_ll = 1'b0; dec_dest = dest;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    tick();
    idle();
  endtask

  // Monitor: every handshake of the HAZ_DEPTH=1 instance must match the next expected entry.
  task automatic run_monitor();
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        n_vec++;
        if (count > 3'd4 || (ds_valid && count == 3'd0)) begin
          n_fail++;
          $display("FAIL occupancy: count=%0d ds_valid=%0b, expected count<=4 and no issue when empty",
                   count, ds_valid);
        end
        if (ds_valid && ds_ready) begin
          n_vec++;
          if (scb.size() == 0) begin
            n_fail++;
            $display("FAIL issue_unexpected: got pc=%h inst=%h, expected no issue", ds_pc, ds_inst);
          end else begin
            e = scb.pop_front();
            if ({ds_pc, ds_inst, ds_adef} !== e) begin
              n_fail++;
              $display("FAIL issue_order: got pc=%h inst=%h adef=%0b, expected pc=%h inst=%h adef=%0b",
                       ds_pc, ds_inst, ds_adef, e[64:33], e[32:1], e[0]);
            end
          end
        end
      end
    end
  endtask

  localparam logic [31:0] Pc0 = 32'h1c00_0000;

  initial begin
    fork
      run_monitor();
    join_none

    // Reset
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_fs_ready", fs_ready, 1);
    chk("rst_ds_valid", ds_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ds_pc", ds_pc, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;

    // 1: fill to full, refuse a 5th push, then drain in order
    for (int k = 0; k < 4; k++) begin
      idle();
      drive_push(Pc0 + 32'(4 * k), mk_r(5'(10 + k), 5'd0, 5'd0), 1'b0);
      exp_issue(Pc0 + 32'(4 * k), mk_r(5'(10 + k), 5'd0, 5'd0), 1'b0);
      settle();
      chk("t1_fs_ready_filling", fs_ready, 1);
      tick();
    end
    idle();
    settle();
    chk("t1_count_full", count, 4);
    chk("t1_fs_ready_full", fs_ready, 0);
    chk("t1_head_pc", ds_pc, Pc0);
    drive_push(Pc0 + 32'h10, mk_r(5'd20, 5'd0, 5'd0), 1'b0);
    tick();
    chk("t1_push5_refused", count, 4);
    idle();
    drive_push(Pc0 + 32'h10, mk_r(5'd20, 5'd0, 5'd0), 1'b0);
    ds_ready = 1'b1;
    settle();
    chk("t1_full_pop_no_push_ready", fs_ready, 0);
    tick();
    chk("t1_count_after_pop", count, 3);
    for (int j = 0; j < 3; j++) begin
      idle();
      ds_ready = 1'b1;
      tick();
      chk("t1_drain_count", count, 64'(2 - j));
    end
    chk("t1_empty_ds_valid", ds_valid, 0);

    // 2: steady push+pop at count=2 across pointer wrap
    for (int k = 0; k < 2; k++) begin
      idle();
      drive_push(32'h1c00_1000 + 32'(4 * k), mk_r(5'(1 + k), 5'd0, 5'd0), 1'b0);
      exp_issue(32'h1c00_1000 + 32'(4 * k), mk_r(5'(1 + k), 5'd0, 5'd0), 1'b0);
      tick();
    end
    chk("t2_count_start", count, 2);
    for (int i = 2; i < 12; i++) begin
      idle();
      drive_push(32'h1c00_1000 + 32'(4 * i), mk_r(5'(1 + i), 5'd0, 5'd0), 1'b0);
      exp_issue(32'h1c00_1000 + 32'(4 * i), mk_r(5'(1 + i), 5'd0, 5'd0), 1'b0);
      ds_ready = 1'b1;
      tick();
      chk("t2_count_steady", count, 2);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      ds_ready = 1'b1;
      tick();
    end
    chk("t2_count_drained", count, 0);

    // 3: load-use with HAZ_DEPTH=1, r0 destination, ADEF head
    do_flush();
    drive_push(32'h1c00_2000, mk_ld(5'd5, 5'd1), 1'b0);
    exp_issue(32'h1c00_2000, mk_ld(5'd5, 5'd1), 1'b0);
    tick();
    idle();
    drive_push(32'h1c00_2004, mk_r(5'd6, 5'd5, 5'd4), 1'b0);
    exp_issue(32'h1c00_2004, mk_r(5'd6, 5'd5, 5'd4), 1'b0);
    tick();
    idle(); ds_ready = 1'b1; dec_load(5'd5);
    settle();
    chk("t3_ld_valid", ds_valid, 1);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t3_use_stall", stall, 1);
    chk("t3_use_blocked", ds_valid, 0);
    chk("t3_use_pc_zero", ds_pc, 0);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t3_use_stall_over", stall, 0);
    chk("t3_use_issued", ds_valid, 1);
    tick();
    chk("t3_count_end", count, 0);

    do_flush();
    drive_push(32'h1c00_2100, mk_ld(5'd0, 5'd1), 1'b0);
    exp_issue(32'h1c00_2100, mk_ld(5'd0, 5'd1), 1'b0);
    tick();
    idle();
    drive_push(32'h1c00_2104, mk_r(5'd6, 5'd0, 5'd4), 1'b0);
    exp_issue(32'h1c00_2104, mk_r(5'd6, 5'd0, 5'd4), 1'b0);
    tick();
    idle(); ds_ready = 1'b1; dec_load(5'd0);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t3_r0_no_stall", stall, 0);
    chk("t3_r0_valid", ds_valid, 1);
    tick();

    do_flush();
    drive_push(32'h1c00_2200, mk_ld(5'd5, 5'd1), 1'b0);
    exp_issue(32'h1c00_2200, mk_ld(5'd5, 5'd1), 1'b0);
    tick();
    idle();
    drive_push(32'h1c00_2204, mk_r(5'd6, 5'd5, 5'd4), 1'b1);
    exp_issue(32'h1c00_2204, mk_r(5'd6, 5'd5, 5'd4), 1'b1);
    tick();
    idle(); ds_ready = 1'b1; dec_load(5'd5);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t3_adef_no_stall", stall, 0);
    chk("t3_adef_flag", ds_adef, 1);
    tick();

    // 4a: HAZ_DEPTH=2 load-use stalls two cycles
    do_flush();
    drive_push(32'h1c00_3000, mk_ld(5'd5, 5'd1), 1'b0);
    exp_issue(32'h1c00_3000, mk_ld(5'd5, 5'd1), 1'b0);
    tick();
    idle();
    drive_push(32'h1c00_3004, mk_r(5'd6, 5'd5, 5'd4), 1'b0);
    exp_issue(32'h1c00_3004, mk_r(5'd6, 5'd5, 5'd4), 1'b0);
    tick();
    idle(); ds_ready = 1'b1; dec_load(5'd5);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t4_h2_stall_c1", stall2, 1);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t4_h2_stall_c2", stall2, 1);
    chk("t4_h1_issued_c2", ds_valid, 1);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t4_h2_valid_c3", ds_valid2, 1);
    chk("t4_h2_pc_c3", ds_pc2, 32'h1c00_3004);
    tick();
    chk("t4_h2_count_end", count2, 0);

    // 4b: ds_ready=0 during the stall holds the scoreboard
    do_flush();
    drive_push(32'h1c00_3100, mk_ld(5'd5, 5'd1), 1'b0);
    exp_issue(32'h1c00_3100, mk_ld(5'd5, 5'd1), 1'b0);
    tick();
    idle();
    drive_push(32'h1c00_3104, mk_r(5'd6, 5'd4, 5'd5), 1'b0);
    exp_issue(32'h1c00_3104, mk_r(5'd6, 5'd4, 5'd5), 1'b0);
    tick();
    idle(); ds_ready = 1'b1; dec_load(5'd5);
    tick();
    for (int c = 0; c < 3; c++) begin
      idle(); dec_alu(5'd6);
      settle();
      chk("t4_hold_stall_h2", stall2, 1);
      chk("t4_hold_stall_h1", stall, 1);
      tick();
    end
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t4_resume_stall_h2_a", stall2, 1);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t4_resume_stall_h2_b", stall2, 1);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t4_resume_valid_h2", ds_valid2, 1);
    tick();

    // 5: branch kill with three queued entries; older load still blocks
    do_flush();
    drive_push(32'h1c00_4000, mk_ld(5'd5, 5'd1), 1'b0);
    exp_issue(32'h1c00_4000, mk_ld(5'd5, 5'd1), 1'b0);
    tick();
    idle(); ds_ready = 1'b1; dec_load(5'd5);
    drive_push(32'h1c00_4004, mk_r(5'd7, 5'd8, 5'd9), 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      idle(); dec_alu(5'd7);
      drive_push(32'h1c00_4008 + 32'(4 * k), mk_r(5'd7, 5'd8, 5'd9), 1'b0);
      tick();
    end
    chk("t5_count_before_br", count, 3);
    idle(); br_taken = 1'b1;
    drive_push(32'h1c00_4010, mk_r(5'd7, 5'd8, 5'd9), 1'b0);
    tick();
    idle();
    settle();
    chk("t5_count_after_br", count, 0);
    chk("t5_fs_ready_after_br", fs_ready, 1);
    chk("t5_ds_valid_after_br", ds_valid, 0);
    drive_push(32'h1c00_5000, mk_r(5'd6, 5'd5, 5'd4), 1'b0);
    exp_issue(32'h1c00_5000, mk_r(5'd6, 5'd5, 5'd4), 1'b0);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t5_sb_survives_br", stall, 1);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t5_dep_issued", ds_valid, 1);
    chk("t5_dep_pc", ds_pc, 32'h1c00_5000);
    tick();

    // 6: flush with br_taken and a pending hazard; then reset with count=3
    do_flush();
    drive_push(32'h1c00_6000, mk_ld(5'd5, 5'd1), 1'b0);
    exp_issue(32'h1c00_6000, mk_ld(5'd5, 5'd1), 1'b0);
    tick();
    idle(); ds_ready = 1'b1; dec_load(5'd5);
    drive_push(32'h1c00_6004, mk_r(5'd6, 5'd5, 5'd4), 1'b0);
    tick();
    idle(); dec_alu(5'd6);
    settle();
    chk("t6_pending_stall", stall, 1);
    flush = 1'b1; br_taken = 1'b1;
    drive_push(32'h1c00_6008, mk_r(5'd6, 5'd5, 5'd4), 1'b0);
    tick();
    idle();
    settle();
    chk("t6_flush_count", count, 0);
    chk("t6_flush_stall", stall, 0);
    chk("t6_flush_fs_ready", fs_ready, 1);
    drive_push(32'h1c00_600c, mk_r(5'd6, 5'd5, 5'd4), 1'b0);
    exp_issue(32'h1c00_600c, mk_r(5'd6, 5'd5, 5'd4), 1'b0);
    tick();
    idle(); ds_ready = 1'b1; dec_alu(5'd6);
    settle();
    chk("t6_sb_cleared", stall, 0);
    chk("t6_issue_after_flush", ds_valid, 1);
    tick();

    for (int k = 0; k < 3; k++) begin
      idle();
      drive_push(32'h1c00_7000 + 32'(4 * k), mk_r(5'd3, 5'd2, 5'd1), 1'b0);
      tick();
    end
    idle();
    chk("t6_count_before_reset", count, 3);
    reset = 1'b1;
    tick();
    settle();
    chk("t6_rst_count", count, 0);
    chk("t6_rst_fs_ready", fs_ready, 1);
    chk("t6_rst_ds_valid", ds_valid, 0);
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_ds_pc", ds_pc, 0);
    chk("t6_rst_ds_inst", ds_inst, 0);
    chk("t6_rst_ds_adef", ds_adef, 0);
    reset = 1'b0;
    tick();

    chk("all_expected_issued", 64'(scb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
